// File: rtl/decision_tree_multifeat_pipe_if.sv
// Bundle of sample, result and node-programming signals for the
// multi-feature decision tree engine. slave = engine side, master = driver side.
interface decision_tree_multifeat_pipe_if #(
  parameter int NUM_FEATURES = 4,
  parameter int FEAT_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 6,
  parameter int ACT_WIDTH    = 2,
  parameter int TAG_WIDTH    = 4
);
  localparam int FSEL_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

  logic                               in_valid;
  logic                               in_ready;
  logic [NUM_FEATURES*FEAT_WIDTH-1:0] in_features;
  logic [TAG_WIDTH-1:0]               in_tag;
  logic                               out_valid;
  logic                               out_ready;
  logic [ACT_WIDTH-1:0]               out_action;
  logic [TAG_WIDTH-1:0]               out_tag;
  logic                               out_err;
  logic                               sw_we;
  logic [ADDR_WIDTH-1:0]              sw_addr;
  logic                               sw_is_leaf;
  logic [FSEL_W-1:0]                  sw_feat_sel;
  logic [FEAT_WIDTH-1:0]              sw_threshold;
  logic [1:0]                         sw_cmp;
  logic [ADDR_WIDTH-1:0]              sw_left_idx;
  logic [ADDR_WIDTH-1:0]              sw_right_idx;
  logic [ACT_WIDTH-1:0]               sw_action;
  logic                               sw_commit;
  logic                               active_bank;

  modport slave (
    input  in_valid, in_features, in_tag, out_ready,
    input  sw_we, sw_addr, sw_is_leaf, sw_feat_sel, sw_threshold, sw_cmp,
    input  sw_left_idx, sw_right_idx, sw_action, sw_commit,
    output in_ready, out_valid, out_action, out_tag, out_err, active_bank
  );

  modport master (
    output in_valid, in_features, in_tag, out_ready,
    output sw_we, sw_addr, sw_is_leaf, sw_feat_sel, sw_threshold, sw_cmp,
    output sw_left_idx, sw_right_idx, sw_action, sw_commit,
    input  in_ready, out_valid, out_action, out_tag, out_err, active_bank
  );
endinterface

// File: rtl/decision_tree_multifeat_pipe.sv
// Pipelined multi-feature decision tree classifier, one stage per tree level.
// Double-banked node memory: software writes the shadow bank and commits to swap.
// Each sample carries the bank it was accepted on, so a reload never mixes trees.
// Optional feature macro: DT_TRAVERSAL_ERR_EN (flags overrun / out-of-range index
// on out_err and terminates out-of-range samples; otherwise indices wrap).
module decision_tree_multifeat_pipe #(
  parameter int NUM_FEATURES = 4,
  parameter int FEAT_WIDTH   = 8,
  parameter int MAX_NODES    = 64,
  parameter int MAX_DEPTH    = 6,
  parameter int ADDR_WIDTH   = 6,
  parameter int ACT_WIDTH    = 2,
  parameter int TAG_WIDTH    = 4
) (
  input logic                          clk,
  input logic                          rst_n,
  decision_tree_multifeat_pipe_if.slave io_bus
);
  localparam int STAGES = MAX_DEPTH;
  localparam int FSEL_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [ADDR_WIDTH:0] LP_NODES = (ADDR_WIDTH+1)'(MAX_NODES);

  typedef struct packed {
    logic                  is_leaf;
    logic [FSEL_W-1:0]     feat_sel;
    logic [FEAT_WIDTH-1:0] thr;
    logic [1:0]            cmp;
    logic [ADDR_WIDTH-1:0] left;
    logic [ADDR_WIDTH-1:0] right;
    logic [ACT_WIDTH-1:0]  action;
  } node_t;

  // One in-flight sample: payload plus traversal state.
  typedef struct packed {
    logic [TAG_WIDTH-1:0]                       tag;
    logic [NUM_FEATURES-1:0][FEAT_WIDTH-1:0]    feat;
    logic                                       bank;
    logic [ADDR_WIDTH-1:0]                      node;
    logic                                       done;
    logic [ACT_WIDTH-1:0]                       act;
`ifdef DT_TRAVERSAL_ERR_EN
    logic                                       err;
`endif
  } slot_t;

  node_t                 r_mem [2][MAX_NODES];
  logic                  r_active_bank;
  logic [STAGES:0]       r_vld_pipe;
  slot_t                 r_slot [STAGES+1];
  logic                  r_out_valid;
  logic [ACT_WIDTH-1:0]  r_out_action;
  logic [TAG_WIDTH-1:0]  r_out_tag;
`ifdef DT_TRAVERSAL_ERR_EN
  logic                  r_out_err;
`endif

  logic                  w_stall;
  logic                  w_accept;
  node_t                 w_wr_node;
  slot_t                 w_in;
  node_t                 w_nd   [STAGES];
  logic [FEAT_WIDTH-1:0] w_f    [STAGES];
  logic                  w_take [STAGES];
  logic [ADDR_WIDTH-1:0] w_nxt  [STAGES];
  slot_t                 w_next [STAGES];

  // Only a held result blocks the pipe; everything advances in lockstep otherwise.
  assign w_stall  = r_out_valid && !io_bus.out_ready;
  assign w_accept = io_bus.in_valid && !w_stall;

  assign io_bus.in_ready    = !w_stall;
  assign io_bus.out_valid   = r_out_valid;
  assign io_bus.out_action  = r_out_action;
  assign io_bus.out_tag     = r_out_tag;
  assign io_bus.active_bank = r_active_bank;
`ifdef DT_TRAVERSAL_ERR_EN
  assign io_bus.out_err     = r_out_err;
`else
  assign io_bus.out_err     = 1'b0;
`endif

  // Pack the software write port into a node entry.
  always_comb begin
    w_wr_node          = '0;
    w_wr_node.is_leaf  = io_bus.sw_is_leaf;
    w_wr_node.feat_sel = io_bus.sw_feat_sel;
    w_wr_node.thr      = io_bus.sw_threshold;
    w_wr_node.cmp      = io_bus.sw_cmp;
    w_wr_node.left     = io_bus.sw_left_idx;
    w_wr_node.right    = io_bus.sw_right_idx;
    w_wr_node.action   = io_bus.sw_action;
  end

  // Node memory: writes always go to the bank that is shadow before this edge,
  // so a write coinciding with a commit lands in the bank becoming active.
  always_ff @(posedge clk) begin
    if (io_bus.sw_we) r_mem[~r_active_bank][io_bus.sw_addr] <= w_wr_node;
  end

  // New sample starts at node 0 on the currently active bank.
  always_comb begin
    w_in      = '0;
    w_in.tag  = io_bus.in_tag;
    w_in.feat = io_bus.in_features;
    w_in.bank = r_active_bank;
  end

  // Per-level node evaluation; finished samples pass through untouched.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_nd[k]   = r_mem[r_slot[k].bank][r_slot[k].node];
      w_f[k]    = r_slot[k].feat[w_nd[k].feat_sel];
      w_take[k] = 1'b0;
      case (w_nd[k].cmp)
        2'b00: w_take[k] = w_f[k] <  w_nd[k].thr;
        2'b01: w_take[k] = w_f[k] <= w_nd[k].thr;
        2'b10: w_take[k] = w_f[k] >  w_nd[k].thr;
        2'b11: w_take[k] = w_f[k] >= w_nd[k].thr;
      endcase
      w_nxt[k]  = w_take[k] ? w_nd[k].left : w_nd[k].right;
      w_next[k] = r_slot[k];
      if (!r_slot[k].done) begin
        if (w_nd[k].is_leaf) begin
          w_next[k].done = 1'b1;
          w_next[k].act  = w_nd[k].action;
        end else if ({1'b0, w_nxt[k]} >= LP_NODES) begin
`ifdef DT_TRAVERSAL_ERR_EN
          w_next[k].done = 1'b1;
          w_next[k].act  = '0;
          w_next[k].err  = 1'b1;
`else
          w_next[k].node = ADDR_WIDTH'({1'b0, w_nxt[k]} % LP_NODES);
`endif
        end else begin
          w_next[k].node = w_nxt[k];
        end
      end
    end
  end

  // Stage datapath registers; no reset needed, validity lives in r_vld_pipe.
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_slot[0] <= w_in;
      for (int k = 0; k < STAGES; k++) r_slot[k+1] <= w_next[k];
    end
  end

  // Control state: bank select, stage valids and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_bank <= 1'b0;
      r_vld_pipe    <= '0;
      r_out_valid   <= 1'b0;
      r_out_action  <= '0;
      r_out_tag     <= '0;
`ifdef DT_TRAVERSAL_ERR_EN
      r_out_err     <= 1'b0;
`endif
    end else begin
      if (io_bus.sw_commit) r_active_bank <= ~r_active_bank;
      if (!w_stall) begin
        r_vld_pipe  <= {r_vld_pipe[STAGES-1:0], w_accept};
        r_out_valid <= r_vld_pipe[STAGES];
        if (r_vld_pipe[STAGES]) begin
          // Not at a leaf after all visits means overrun: action 0.
          r_out_action <= r_slot[STAGES].done ? r_slot[STAGES].act : '0;
          r_out_tag    <= r_slot[STAGES].tag;
`ifdef DT_TRAVERSAL_ERR_EN
          r_out_err    <= r_slot[STAGES].err | ~r_slot[STAGES].done;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_decision_tree_multifeat_pipe.sv
// Directed bench for decision_tree_multifeat_pipe: tree load, boundaries,
// back-to-back flow, backpressure, live reload, reset and overrun.
module tb_decision_tree_multifeat_pipe;
`ifdef DT_TRAVERSAL_ERR_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  decision_tree_multifeat_pipe_if bus ();

  decision_tree_multifeat_pipe u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
    end
  endtask

  task automatic wr_node(input int a, input int leaf, input int fs, input int thr,
                         input int cmp, input int l, input int r, input int act);
    bus.sw_we        = 1'b1;
    bus.sw_addr      = 6'(a);
    bus.sw_is_leaf   = 1'(leaf);
    bus.sw_feat_sel  = 2'(fs);
    bus.sw_threshold = 8'(thr);
    bus.sw_cmp       = 2'(cmp);
    bus.sw_left_idx  = 6'(l);
    bus.sw_right_idx = 6'(r);
    bus.sw_action    = 2'(act);
    @(negedge clk);
    bus.sw_we        = 1'b0;
  endtask

  task automatic load_tree(input int a3);
    wr_node(0, 0, 0, 10, 0, 1, 2, 0);
    wr_node(1, 0, 1, 20, 1, 3, 4, 0);
    wr_node(2, 0, 0, 5,  2, 5, 6, 0);
    wr_node(3, 1, 0, 0, 0, 0, 0, a3);
    wr_node(4, 1, 0, 0, 0, 0, 0, 2);
    wr_node(5, 1, 0, 0, 0, 0, 0, 3);
    wr_node(6, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic commit();
    bus.sw_commit = 1'b1;
    @(negedge clk);
    bus.sw_commit = 1'b0;
  endtask

  task automatic drive(input int f0, input int f1, input int tg);
    bus.in_features = {16'd0, 8'(f1), 8'(f0)};
    bus.in_tag      = 4'(tg);
    bus.in_valid    = 1'b1;
    #1 chk("drv_rdy", int'(bus.in_ready), 1);
    @(negedge clk);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_one(input string nm, input int f0, input int f1, input int tg,
                         input int act, input int err);
    int n;
    drive(f0, f1, tg);
    bus.in_valid = 1'b0;
    wait_valid(n);
    chk({nm, "_lat"}, n, 7);
    chk({nm, "_act"}, int'(bus.out_action), act);
    chk({nm, "_tag"}, int'(bus.out_tag), tg);
    chk({nm, "_err"}, int'(bus.out_err), err);
  endtask

  initial begin
    int n;
    int seen;
    bus.in_valid = 0; bus.in_features = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
    bus.sw_we = 0; bus.sw_addr = '0; bus.sw_is_leaf = 0; bus.sw_feat_sel = '0;
    bus.sw_threshold = '0; bus.sw_cmp = '0; bus.sw_left_idx = '0; bus.sw_right_idx = '0;
    bus.sw_action = '0; bus.sw_commit = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid",  int'(bus.out_valid), 0);
    chk("rst_action", int'(bus.out_action), 0);
    chk("rst_tag",    int'(bus.out_tag), 0);
    chk("rst_err",    int'(bus.out_err), 0);
    chk("rst_bank",   int'(bus.active_bank), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: load into shadow bank 1, commit, classify
    load_tree(1);
    commit();
    chk("t1_bank", int'(bus.active_bank), 1);
    run_one("t1_a", 5, 7, 0, 1, 0);
    run_one("t1_le", 5, 20, 1, 1, 0);
    run_one("t1_gt", 5, 21, 2, 2, 0);
    run_one("t1_r", 15, 0, 3, 3, 0);
    run_one("t1_f0eq", 10, 0, 4, 3, 0);

    // T2: back-to-back
    drive(5, 7, 1); drive(5, 21, 2); drive(15, 0, 3);
    bus.in_valid = 1'b0;
    wait_valid(n);
    chk("t2_lat", n, 5);
    for (int i = 0; i < 3; i++) begin
      chk("t2_v",   int'(bus.out_valid), 1);
      chk("t2_tag", int'(bus.out_tag), i + 1);
      chk("t2_act", int'(bus.out_action), i + 1);
      @(negedge clk);
    end
    chk("t2_end", int'(bus.out_valid), 0);

    // T3: backpressure for 4 cycles
    drive(5, 7, 7); drive(5, 21, 8); drive(15, 0, 9);
    bus.in_valid = 1'b0;
    wait_valid(n);
    chk("t3_lat", n, 5);
    chk("t3_tag7", int'(bus.out_tag), 7);
    bus.out_ready = 1'b0;
    #1 chk("t3_rdy_lo", int'(bus.in_ready), 0);
    repeat (4) begin
      @(negedge clk);
      chk("t3_hold_v",   int'(bus.out_valid), 1);
      chk("t3_hold_tag", int'(bus.out_tag), 7);
      chk("t3_hold_rdy", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    #1 chk("t3_rdy_hi", int'(bus.in_ready), 1);
    @(negedge clk);
    chk("t3_v8",   int'(bus.out_valid), 1);
    chk("t3_tag8", int'(bus.out_tag), 8);
    chk("t3_act8", int'(bus.out_action), 2);
    @(negedge clk);
    chk("t3_v9",   int'(bus.out_valid), 1);
    chk("t3_tag9", int'(bus.out_tag), 9);
    chk("t3_act9", int'(bus.out_action), 3);
    @(negedge clk);
    chk("t3_end", int'(bus.out_valid), 0);

    // T4: live reload, shadow bank 0 gets n3=2
    load_tree(2);
    drive(5, 7, 5);
    bus.in_valid = 1'b0;
    commit();
    chk("t4_bank", int'(bus.active_bank), 0);
    drive(5, 7, 6);
    bus.in_valid = 1'b0;
    wait_valid(n);
    chk("t4_lat5", n, 5);
    chk("t4_tag5", int'(bus.out_tag), 5);
    chk("t4_act5", int'(bus.out_action), 1);
    @(negedge clk);
    wait_valid(n);
    chk("t4_v6",   int'(bus.out_valid), 1);
    chk("t4_tag6", int'(bus.out_tag), 6);
    chk("t4_act6", int'(bus.out_action), 2);
    @(negedge clk);

    // write + commit in the same cycle: n4=1 lands in bank 1, which becomes active
    bus.sw_commit = 1'b1;
    wr_node(4, 1, 0, 0, 0, 0, 0, 1);
    bus.sw_commit = 1'b0;
    chk("t4s_bank", int'(bus.active_bank), 1);
    run_one("t4s", 5, 21, 11, 1, 0);

    // T6: async reset mid-stream
    drive(5, 7, 1); drive(15, 0, 2); drive(5, 7, 3);
    bus.in_valid = 1'b0;
    wait_valid(n);
    chk("t6_pre", int'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid",  int'(bus.out_valid), 0);
    chk("t6_action", int'(bus.out_action), 0);
    chk("t6_tag",    int'(bus.out_tag), 0);
    chk("t6_err",    int'(bus.out_err), 0);
    chk("t6_bank",   int'(bus.active_bank), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("t6_stale", seen, 0);
    run_one("t6_post", 5, 7, 12, 2, 0);

    // T5: overrun, n0 loops to itself with no leaf
    wr_node(0, 0, 0, 255, 0, 0, 0, 0);
    commit();
    chk("t5_bank", int'(bus.active_bank), 1);
    run_one("t5", 0, 0, 13, 0, EXP_ERR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
